// File: rtl/bank_accounter.sv
// bank_accounter: records which write agent/bank last wrote each address, and looks up that bank for each read agent
// Optional feature: define BANK_ACCOUNTER_BYPASS_EN for same-cycle write-to-lookup forwarding (write-first banks).
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset (clears the whole table)
//   m_wren, m_wraddr       per-write-agent enable and address
//   m_rden, m_rdaddr       per-read-agent enable and address (the enable only qualifies the result)
//   bank_select            per-read-agent {collision, bank_idx}, combinational from m_rdaddr
module bank_accounter #(
    parameter int ADDR_WIDTH      = 8,
    parameter int NB_WRAGENT      = 2,
    parameter int NB_RDAGENT      = 2,
    parameter int WRITE_COLLISION = 1,
    parameter int SELECT_WIDTH    = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NB_WRAGENT-1:0]              m_wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   m_wraddr,
    input  logic [NB_RDAGENT-1:0]              m_rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [SELECT_WIDTH-1:0] r_table [DEPTH];
    logic [NB_WRAGENT-1:0]   w_win;
    logic [SELECT_WIDTH-1:0] w_entry [NB_WRAGENT];
    logic                    w_unused_rden;
    assign w_unused_rden = ^m_rden;
    // Each enabled agent is the winner for its address unless a higher-index agent hits the same address;
    // the collision bit marks any other enabled agent on that address.
    always_comb begin
        for (int i = 0; i < NB_WRAGENT; i++) begin
            w_win[i]   = m_wren[i];
            w_entry[i] = SELECT_WIDTH'(i);
            for (int j = 0; j < NB_WRAGENT; j++)
                if (j != i && m_wren[j] && m_wraddr[j*ADDR_WIDTH +: ADDR_WIDTH] == m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    if (j > i) w_win[i] = 1'b0;
                    if (WRITE_COLLISION != 0) w_entry[i][SELECT_WIDTH-1] = 1'b1;
                end
        end
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int a = 0; a < DEPTH; a++) r_table[a] <= '0;
        end else begin
            for (int i = 0; i < NB_WRAGENT; i++)
                if (w_win[i]) r_table[m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= w_entry[i];
        end
    end
    always_comb begin
        for (int r = 0; r < NB_RDAGENT; r++) begin
            bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = r_table[m_rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef BANK_ACCOUNTER_BYPASS_EN
            for (int i = 0; i < NB_WRAGENT; i++)
                if (w_win[i] && m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == m_rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH])
                    bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = w_entry[i];
`else
`endif
        end
    end
endmodule

// File: tb/tb_bank_accounter.sv
// tb_bank_accounter: vector table, hand sequences and randomized model comparison for bank_accounter
module tb_bank_accounter;
    logic        aclk = 0;
    logic        aresetn = 0;
    logic [1:0]  m_wren = '0;
    logic [15:0] m_wraddr = '0;
    logic [1:0]  m_rden = '0;
    logic [15:0] m_rdaddr = '0;
    logic [3:0]  bank_select;
    int checks = 0;
    int failures = 0;
    logic [1:0] model [256];

    bank_accounter dut (
        .aclk(aclk), .aresetn(aresetn), .m_wren(m_wren), .m_wraddr(m_wraddr),
        .m_rden(m_rden), .m_rdaddr(m_rdaddr), .bank_select(bank_select)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0] wren;
        logic [7:0] wa0, wa1, ra0, ra1;
        logic [1:0] e0, e1;
    } vec_t;

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wren, input logic [7:0] wa0, input logic [7:0] wa1,
                         input logic [7:0] ra0, input logic [7:0] ra1);
        @(negedge aclk);
        m_wren = wren;
        m_wraddr = {wa1, wa0};
        m_rden = 2'b11;
        m_rdaddr = {ra1, ra0};
        #1;
    endtask

    // Expected lookup: with forwarding, any agents writing the address this cycle decide it; else last committed value.
    function automatic logic [1:0] expect_sel(input logic [7:0] a);
`ifdef BANK_ACCOUNTER_BYPASS_EN
        int cnt = 0;
        int win = 0;
        for (int i = 0; i < 2; i++)
            if (m_wren[i] && m_wraddr[i*8 +: 8] == a) begin
                cnt++;
                win = i;
            end
        if (cnt > 0) return {cnt > 1, win[0]};
`else
`endif
        return model[a];
    endfunction

    // Commit the current cycle's writes: highest-index writer owns the address, collision when 2+ writers hit it.
    task automatic commit();
        logic [1:0] upd [256];
        bit         hit [256];
        int         cnt [256];
        for (int a = 0; a < 256; a++) begin
            hit[a] = 0;
            cnt[a] = 0;
            upd[a] = '0;
        end
        for (int i = 0; i < 2; i++)
            if (m_wren[i]) begin
                cnt[m_wraddr[i*8 +: 8]]++;
                hit[m_wraddr[i*8 +: 8]] = 1;
                upd[m_wraddr[i*8 +: 8]][0] = 1'(i);
            end
        for (int a = 0; a < 256; a++)
            if (hit[a]) model[a] = {cnt[a] > 1, upd[a][0]};
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{2'b00, 8'h00, 8'h00, 8'h10, 8'h11, 2'b00, 2'b00};
        vecs[1]  = '{2'b10, 8'h00, 8'h10, 8'hFF, 8'hFF, 2'b00, 2'b00};
        vecs[2]  = '{2'b00, 8'h00, 8'h00, 8'h10, 8'h11, 2'b01, 2'b00};
        vecs[3]  = '{2'b11, 8'h20, 8'h20, 8'hFF, 8'hFF, 2'b00, 2'b00};
        vecs[4]  = '{2'b00, 8'h00, 8'h00, 8'h20, 8'h20, 2'b11, 2'b11};
        vecs[5]  = '{2'b01, 8'h20, 8'h00, 8'hFF, 8'hFF, 2'b00, 2'b00};
        vecs[6]  = '{2'b00, 8'h00, 8'h00, 8'h20, 8'h10, 2'b00, 2'b01};
        vecs[7]  = '{2'b11, 8'h40, 8'h41, 8'hFF, 8'hFF, 2'b00, 2'b00};
        vecs[8]  = '{2'b00, 8'h00, 8'h00, 8'h40, 8'h41, 2'b00, 2'b01};
`ifdef BANK_ACCOUNTER_BYPASS_EN
        vecs[9]  = '{2'b10, 8'h00, 8'h30, 8'h30, 8'hFF, 2'b01, 2'b00};
`else
        vecs[9]  = '{2'b10, 8'h00, 8'h30, 8'h30, 8'hFF, 2'b00, 2'b00};
`endif
        vecs[10] = '{2'b00, 8'h00, 8'h00, 8'h30, 8'h30, 2'b01, 2'b01};

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_hold", bank_select[1:0], 2'b00);
        @(negedge aclk);
        aresetn = 1;

        for (int k = 0; k < 11; k++) begin
            drive(vecs[k].wren, vecs[k].wa0, vecs[k].wa1, vecs[k].ra0, vecs[k].ra1);
            chk($sformatf("vec%0d_rd0", k), bank_select[1:0], vecs[k].e0);
            chk($sformatf("vec%0d_rd1", k), bank_select[3:2], vecs[k].e1);
        end

        drive(2'b11, 8'h20, 8'h20, 8'h10, 8'h20);
        drive(2'b00, 8'h00, 8'h00, 8'h10, 8'h20);
        chk("pre_rst_10", bank_select[1:0], 2'b01);
        chk("pre_rst_20", bank_select[3:2], 2'b11);
        drive(2'b11, 8'h10, 8'h20, 8'h10, 8'h20);
        aresetn = 0;
        #1;
        chk("async_rst_10", bank_select[1:0], 2'b00);
        chk("async_rst_20", bank_select[3:2], 2'b00);
        repeat (3) drive(2'b11, 8'h10, 8'h20, 8'h10, 8'h20);
        chk("in_rst_write_dropped", bank_select[3:2], 2'b00);
        m_wren = 2'b00;
        aresetn = 1;
        #1;
        chk("post_rst_10", bank_select[1:0], 2'b00);
        chk("post_rst_20", bank_select[3:2], 2'b00);
        drive(2'b10, 8'h00, 8'h50, 8'h10, 8'h20);
        drive(2'b00, 8'h00, 8'h00, 8'h50, 8'h20);
        chk("first_wr_after_rst", bank_select[1:0], 2'b01);
        chk("unwritten_after_rst", bank_select[3:2], 2'b00);

        @(negedge aclk);
        aresetn = 0;
        m_wren = 2'b00;
        for (int a = 0; a < 256; a++) model[a] = '0;
        @(negedge aclk);
        aresetn = 1;
        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                  8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
            m_rden = 2'($urandom);
            #1;
            chk("rand_rd0", bank_select[1:0], expect_sel(m_rdaddr[7:0]));
            chk("rand_rd1", bank_select[3:2], expect_sel(m_rdaddr[15:8]));
            commit();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
